// File: rtl/writeback_arbiter_if.sv
// Bus between the result producers / decode stage and the writeback arbiter.
// The master side drives the ALU and memory results and the hazard query.
// The slave side (the arbiter) returns the handshake, stall, hazard flags
// and the register-file write port.
interface writeback_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          aluValid;
    logic [4:0]    aluAddr;
    logic [31:0]   aluData;
    logic          memValid;
    logic          memReady;
    logic [4:0]    memAddr;
    logic [31:0]   memData;
    logic          aluStall;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rsBusy;
    logic          rtBusy;
    logic          regWrite;
    logic [4:0]    rWriteAddress;
    logic [31:0]   rWriteValue;
    logic [CW-1:0] count;

    modport master (
        output aluValid, aluAddr, aluData,
        output memValid, memAddr, memData,
        output rs, rt,
        input  memReady, aluStall, rsBusy, rtBusy,
        input  regWrite, rWriteAddress, rWriteValue, count
    );

    modport slave (
        input  aluValid, aluAddr, aluData,
        input  memValid, memAddr, memData,
        input  rs, rt,
        output memReady, aluStall, rsBusy, rtBusy,
        output regWrite, rWriteAddress, rWriteValue, count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter for the 32x32 register file.
// Merges the unbuffered single-cycle ALU result (highest priority) with the
// multi-cycle memory/muldiv result, which is queued in a small FIFO. ALU writes
// kill older queued writes to the same register; killed slots still occupy the
// FIFO and pop later without writing. A starvation FSM stalls the ALU once the
// FIFO has been blocked for STARVE_LIMIT consecutive cycles.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                 clk,
    input logic                 rst,
    writeback_arbiter_if.slave  io_wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    // FIFO storage; valid bits live apart so kills can clear them in place
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    logic [SW-1:0]    r_starve;
    logic             r_aluStall;

    logic             r_regWrite;
    logic [4:0]       r_wAddr;
    logic [31:0]      r_wData;

    logic             w_aluIssue;
    logic             w_notEmpty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_headValid;
    logic             w_rsHit;
    logic             w_rtHit;

    // A write to r0 is architecturally a no-op, so it never claims the port.
    assign w_aluIssue  = io_wb.aluValid && (io_wb.aluAddr != 5'd0);
    assign w_notEmpty  = (r_count != '0);
    // Ready depends on occupancy only: a full FIFO refuses even while popping.
    assign w_ready     = (r_count < CW'(DEPTH));
    assign w_push      = io_wb.memValid && w_ready && (io_wb.memAddr != 5'd0);
    // The head leaves whenever the ALU does not use the port, killed or not.
    assign w_pop       = !w_aluIssue && w_notEmpty;
    assign w_headValid = r_vld[r_rptr];

    // Hazard match against live queued entries and the write in flight.
    always_comb begin
        w_rsHit = r_regWrite && (r_wAddr == io_wb.rs);
        w_rtHit = r_regWrite && (r_wAddr == io_wb.rt);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == io_wb.rs)) w_rsHit = 1'b1;
            if (r_vld[i] && (r_addr[i] == io_wb.rt)) w_rtHit = 1'b1;
        end
    end

    assign io_wb.memReady      = w_ready;
    assign io_wb.aluStall      = r_aluStall;
    assign io_wb.rsBusy        = (io_wb.rs != 5'd0) && w_rsHit;
    assign io_wb.rtBusy        = (io_wb.rt != 5'd0) && w_rtHit;
    assign io_wb.regWrite      = r_regWrite;
    assign io_wb.rWriteAddress = r_wAddr;
    assign io_wb.rWriteValue   = r_wData;
    assign io_wb.count         = r_count;

    // FIFO control: kill younger-overwritten entries, then pop, then push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_aluIssue && (r_addr[i] == io_wb.aluAddr)) r_vld[i] <= 1'b0;
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            // The push slot is free, so setting it after the kill loop is safe
            // and keeps a same-address simultaneous enqueue alive.
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FIFO payload capture; contents are only meaningful while the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= io_wb.memAddr;
            r_data[r_wptr] <= io_wb.memData;
        end
    end

    // Register-file write port: ALU first, otherwise a live FIFO head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regWrite <= 1'b0;
            r_wAddr    <= 5'd0;
            r_wData    <= 32'd0;
        end else if (w_aluIssue) begin
            r_regWrite <= 1'b1;
            r_wAddr    <= io_wb.aluAddr;
            r_wData    <= io_wb.aluData;
        end else if (w_pop && w_headValid) begin
            r_regWrite <= 1'b1;
            r_wAddr    <= r_addr[r_rptr];
            r_wData    <= r_data[r_rptr];
        end else begin
            r_regWrite <= 1'b0;
            r_wAddr    <= 5'd0;
            r_wData    <= 32'd0;
        end
    end

    // Starvation FSM: count ALU-blocked cycles, then stall the ALU until one entry drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= NORMAL;
            r_starve   <= '0;
            r_aluStall <= 1'b0;
        end else if (r_state == NORMAL) begin
            if (w_notEmpty && w_aluIssue) begin
                if (r_starve == SW'(STARVE_LIMIT - 1)) begin
                    r_state    <= DRAIN;
                    r_aluStall <= 1'b1;
                    r_starve   <= SW'(STARVE_LIMIT);
                end else begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_starve <= '0;
            end
        end else begin
            // An ALU write during DRAIN still wins the port, so no pop and no exit.
            // The empty check only guards against a stuck stall.
            if (w_pop || !w_notEmpty) begin
                r_state    <= NORMAL;
                r_aluStall <= 1'b0;
                r_starve   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic clk;
    logic rst;

    writeback_arbiter_if #(.DEPTH(DEPTH)) wb();

    writeback_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_wb (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    bit          m_wr;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_drain;
    int          m_cnt;

    // pre-edge samples of the combinational outputs from the last cycle
    logic s_rdy, s_rsb, s_rtb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].a == r) return 1'b1;
        return m_wr && (m_wa == r);
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr    = 1'b0;
        m_wa    = 5'd0;
        m_wd    = 32'd0;
        m_drain = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md);
        int   pre;
        bit   rdy;
        bit   issue;
        bit   popped;
        ent_t h;
        pre    = mq.size();
        rdy    = pre < DEPTH;
        issue  = av && (aa != 5'd0);
        popped = 1'b0;
        if (issue) begin
            foreach (mq[i]) if (mq[i].a == aa) mq[i].v = 1'b0;
            m_wr = 1'b1; m_wa = aa; m_wd = ad;
        end else if (pre > 0) begin
            h      = mq.pop_front();
            popped = 1'b1;
            m_wr   = h.v;
            m_wa   = h.v ? h.a : 5'd0;
            m_wd   = h.v ? h.d : 32'd0;
        end else begin
            m_wr = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
        end
        if (mv && rdy && ma != 5'd0) mq.push_back('{ma, md, 1'b1});
        if (!m_drain) begin
            if (pre > 0 && issue) begin
                m_cnt++;
                if (m_cnt >= STARVE_LIMIT) m_drain = 1'b1;
            end else begin
                m_cnt = 0;
            end
        end else if (popped) begin
            m_drain = 1'b0;
            m_cnt   = 0;
        end
    endtask

    // One clock: drive at negedge, check comb outputs before the edge,
    // check registered outputs 1 time unit after the edge.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] prs, input logic [4:0] prt);
        @(negedge clk);
        wb.aluValid = av; wb.aluAddr = aa; wb.aluData = ad;
        wb.memValid = mv; wb.memAddr = ma; wb.memData = md;
        wb.rs = prs; wb.rt = prt;
        #4;
        s_rdy = wb.memReady; s_rsb = wb.rsBusy; s_rtb = wb.rtBusy;
        chk("memReady", 32'(s_rdy), 32'(m_ready()));
        chk("rsBusy",   32'(s_rsb), 32'(m_busy(prs)));
        chk("rtBusy",   32'(s_rtb), 32'(m_busy(prt)));
        model_step(av, aa, ad, mv, ma, md);
        @(posedge clk);
        #1;
        chk("regWrite", 32'(wb.regWrite), 32'(m_wr));
        if (m_wr) begin
            chk("rWriteAddress", 32'(wb.rWriteAddress), 32'(m_wa));
            chk("rWriteValue",   wb.rWriteValue,        m_wd);
        end
        chk("count",    32'(wb.count),    32'(mq.size()));
        chk("aluStall", 32'(wb.aluStall), 32'(m_drain));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        wb.aluValid = 1'b0; wb.aluAddr = 5'd0; wb.aluData = 32'd0;
        wb.memValid = 1'b0; wb.memAddr = 5'd0; wb.memData = 32'd0;
        wb.rs = 5'd0; wb.rt = 5'd0;
        #1;
        chk("rst_regWrite", 32'(wb.regWrite),      32'd0);
        chk("rst_waddr",    32'(wb.rWriteAddress), 32'd0);
        chk("rst_wvalue",   wb.rWriteValue,        32'd0);
        chk("rst_count",    32'(wb.count),         32'd0);
        chk("rst_aluStall", 32'(wb.aluStall),      32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic [4:0]  rs; logic [4:0] rt;
        logic        e_rdy; logic e_rsb; logic e_rtb;
        logic        e_wr;  logic [4:0] e_wa; logic [31:0] e_wd;
        logic [2:0]  e_cnt; logic e_stall;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic        av, mv;
        logic [4:0]  aa, ma, prs, prt;
        logic [31:0] ad, md;

        rst = 1'b0;
        wb.aluValid = 1'b0; wb.aluAddr = 5'd0; wb.aluData = 32'd0;
        wb.memValid = 1'b0; wb.memAddr = 5'd0; wb.memData = 32'd0;
        wb.rs = 5'd0; wb.rt = 5'd0;
        model_reset();

        //              av    aa     ad            mv    ma     md        rs     rt     rdy   rsb   rtb   wr    wa     wd            cnt   stall
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd1, 1'b0};
        tbl[3] = '{1'b1, 5'd7, 32'h22,       1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h22,       3'd1, 1'b0};
        tbl[4] = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,  5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       3'd1, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
        tbl[6] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
        tbl[7] = '{1'b1, 5'd0, 32'h77,       1'b1, 5'd9, 32'h99, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd1, 1'b0};
        tbl[8] = '{1'b1, 5'd0, 32'h88,       1'b0, 5'd0, 32'h0,  5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99,       3'd0, 1'b0};
        tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0};

        apply_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].rs, tbl[i].rt);
            chk($sformatf("tbl%0d_memReady", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_rsBusy", i),   32'(s_rsb), 32'(tbl[i].e_rsb));
            chk($sformatf("tbl%0d_rtBusy", i),   32'(s_rtb), 32'(tbl[i].e_rtb));
            chk($sformatf("tbl%0d_regWrite", i), 32'(wb.regWrite), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(wb.rWriteAddress), 32'(tbl[i].e_wa));
                chk($sformatf("tbl%0d_wdata", i), wb.rWriteValue, tbl[i].e_wd);
            end
            chk($sformatf("tbl%0d_count", i), 32'(wb.count),    32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_stall", i), 32'(wb.aluStall), 32'(tbl[i].e_stall));
        end

        // Reset mid-burst with three queued entries.
        cycle(1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h101, 5'd0, 5'd0);
        cycle(1'b1, 5'd21, 32'hA1, 1'b1, 5'd2, 32'h102, 5'd0, 5'd0);
        cycle(1'b1, 5'd22, 32'hA2, 1'b1, 5'd3, 32'h103, 5'd0, 5'd0);
        chk("burst_count3", 32'(wb.count), 32'd3);
        apply_reset();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        chk("post_rst_nowrite", 32'(wb.regWrite), 32'd0);
        chk("post_rst_count",   32'(wb.count),    32'd0);

        // Fill the FIFO while the ALU owns the port, then refuse a push during a pop.
        cycle(1'b1, 5'd20, 32'hB0, 1'b1, 5'd1, 32'h201, 5'd0, 5'd0);
        cycle(1'b1, 5'd21, 32'hB1, 1'b1, 5'd2, 32'h202, 5'd0, 5'd0);
        cycle(1'b1, 5'd22, 32'hB2, 1'b1, 5'd3, 32'h203, 5'd0, 5'd0);
        cycle(1'b1, 5'd23, 32'hB3, 1'b1, 5'd4, 32'h204, 5'd0, 5'd0);
        chk("full_count",    32'(wb.count),    32'd4);
        chk("full_memReady", 32'(wb.memReady), 32'd0);
        chk("full_stall",    32'(wb.aluStall), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h205, 5'd0, 5'd0);
        chk("full_refused_rdy", 32'(s_rdy),            32'd0);
        chk("drain1_addr",      32'(wb.rWriteAddress), 32'd1);
        chk("drain1_count",     32'(wb.count),         32'd3);
        chk("drain1_stall",     32'(wb.aluStall),      32'd0);
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            chk($sformatf("drain%0d_wr", i),   32'(wb.regWrite),      32'd1);
            chk($sformatf("drain%0d_addr", i), 32'(wb.rWriteAddress), 32'(i));
            chk($sformatf("drain%0d_data", i), wb.rWriteValue,        32'h200 + 32'(i));
        end
        chk("drained_count", 32'(wb.count), 32'd0);

        // Starvation: one queued entry blocked for three ALU cycles.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hC10, 5'd0, 5'd0);
        cycle(1'b1, 5'd11, 32'hC11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd12, 32'hC12, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("starve_not_yet", 32'(wb.aluStall), 32'd0);
        cycle(1'b1, 5'd13, 32'hC13, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("starve_stall", 32'(wb.aluStall), 32'd1);
        idle(1);
        chk("starve_drain_addr", 32'(wb.rWriteAddress), 32'd10);
        chk("starve_release",    32'(wb.aluStall),      32'd0);

        // Randomized traffic against the model.
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            av  = m_drain ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            aa  = 5'($urandom_range(0, 7));
            ad  = $urandom;
            mv  = ($urandom_range(0, 2) != 0);
            ma  = 5'($urandom_range(0, 7));
            md  = $urandom;
            prs = 5'($urandom_range(0, 7));
            prt = 5'($urandom_range(0, 7));
            cycle(av, aa, ad, mv, ma, md, prs, prt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
